// File: rtl/blink_ctrl_pkg.sv
// Shared encodings for the LED blink controller: channel modes, FSM states and
// small helpers used by the interface, the top and the per-channel engine.
package blink_ctrl_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ON     = 2'd1,
    ST_RUN_HI = 2'd2,
    ST_RUN_LO = 2'd3
  } state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic state_lit(input state_e s);
    return (s == ST_ON) || (s == ST_RUN_HI);
  endfunction

endpackage

// File: rtl/blink_ctrl_if.sv
// Configuration write channel of the blink controller (valid/ready plus payload).
interface blink_ctrl_if
  import blink_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24
);
  localparam int CH_W = ch_width(N_CH);

  logic             CFG_VALID;
  logic             CFG_READY;
  logic [CH_W-1:0]  CFG_CH;
  logic [1:0]       CFG_MODE;
  logic [CNT_W-1:0] CFG_HALF;
  logic [7:0]       CFG_COUNT;

  modport master (
    output CFG_VALID, CFG_CH, CFG_MODE, CFG_HALF, CFG_COUNT,
    input  CFG_READY
  );

  modport slave (
    input  CFG_VALID, CFG_CH, CFG_MODE, CFG_HALF, CFG_COUNT,
    output CFG_READY
  );
endinterface

// File: rtl/blink_chan.sv
// One LED channel: OFF/ON/RUN_HI/RUN_LO FSM with phase counter, burst pulse
// counter and a half-period latched at write time.
module blink_chan
  import blink_ctrl_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [1:0]       wr_mode,
  input  logic [CNT_W-1:0] wr_half,
  input  logic [7:0]       wr_count,
  output logic             led,
  output logic             done
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] phase_reg, phase_next;
  logic [CNT_W-1:0] half_reg, half_next;
  logic [7:0]       pulse_reg, pulse_next;
  logic [7:0]       count_reg, count_next;
  logic             burst_reg, burst_next;
  logic             led_reg, led_next;
  logic             done_reg, done_next;
  logic             phase_end;

  assign phase_end = (phase_reg == half_reg - CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    half_next  = half_reg;
    pulse_next = pulse_reg;
    count_next = count_reg;
    burst_next = burst_reg;
    done_next  = 1'b0;

    case (state_reg)
      ST_RUN_HI: begin
        if (phase_end) begin
          state_next = ST_RUN_LO;
          phase_next = '0;
          if (burst_reg) pulse_next = pulse_reg + 8'd1;
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      ST_RUN_LO: begin
        if (phase_end) begin
          phase_next = '0;
          if (burst_reg && (pulse_reg == count_reg)) begin
            state_next = ST_OFF;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RUN_HI;
          end
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // A write overrides the running activity, but a burst finishing on this
    // very edge still reports its completion through done_next.
    if (wr_en) begin
      half_next  = (wr_half == '0) ? CNT_W'(1) : wr_half;
      count_next = wr_count;
      burst_next = (wr_mode == MODE_BURST);
      phase_next = '0;
      pulse_next = '0;
      case (wr_mode)
        MODE_OFF:   state_next = ST_OFF;
        MODE_ON:    state_next = ST_ON;
        MODE_BLINK: state_next = ST_RUN_HI;
        default: begin
          if (wr_count == 8'd0) begin
            state_next = ST_OFF;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RUN_HI;
          end
        end
      endcase
    end

    led_next = state_lit(state_next);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_OFF;
      phase_reg <= '0;
      half_reg  <= '0;
      pulse_reg <= '0;
      count_reg <= '0;
      burst_reg <= 1'b0;
      led_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      half_reg  <= half_next;
      pulse_reg <= pulse_next;
      count_reg <= count_next;
      burst_reg <= burst_next;
      led_reg   <= led_next;
      done_reg  <= done_next;
    end
  end

  assign led  = led_reg;
  assign done = done_reg;

endmodule

// File: rtl/blink_ctrl.sv
// Multi-channel LED blink controller: write decode and ready generation,
// with one blink_chan engine per channel.
module blink_ctrl
  import blink_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24
) (
  input  logic            CLOCK,
  input  logic            RESET,
  blink_ctrl_if.slave     cfg,
  output logic [N_CH-1:0] LED,
  output logic [N_CH-1:0] DONE
);

  localparam int CH_W = ch_width(N_CH);

  logic            armed_reg;
  logic            ready_reg;
  logic            accept;
  logic [N_CH-1:0] wr_en;

  // Ready comes up one cycle after the first non-reset edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      armed_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      ready_reg <= armed_reg;
    end
  end

  assign cfg.CFG_READY = ready_reg;
  assign accept        = cfg.CFG_VALID && ready_reg;

  // Selects at or above N_CH match no channel and are dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign wr_en[gi] = accept && (cfg.CFG_CH == CH_W'(gi));

    blink_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (CLOCK),
      .srst     (RESET),
      .wr_en    (wr_en[gi]),
      .wr_mode  (cfg.CFG_MODE),
      .wr_half  (cfg.CFG_HALF),
      .wr_count (cfg.CFG_COUNT),
      .led      (LED[gi]),
      .done     (DONE[gi])
    );
  end

endmodule
